// File: rtl/ip_pkg.sv
// Shared IPv4 header constants, state/error encodings and ones-complement helper
// used by the receive checker and the transmit header builder.
package ip_pkg;

    localparam logic [4:0]  OFF_LEN   = 5'd2;
    localparam logic [4:0]  OFF_FLAGS = 5'd6;
    localparam logic [4:0]  OFF_PROTO = 5'd9;
    localparam logic [4:0]  OFF_SRC   = 5'd12;
    localparam logic [4:0]  OFF_DST   = 5'd16;
    localparam logic [4:0]  HDR_LAST  = 5'd19;

    localparam logic [15:0] HDR_LEN          = 16'd20;
    localparam logic [7:0]  VER_IHL          = 8'h45;
    localparam logic [31:0] DEFAULT_LOCAL_IP = 32'hC0A8_0104;
    localparam logic [31:0] BROADCAST_IP     = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_CHECK,
        S_PAYLOAD,
        S_DROP
    } state_t;

    typedef enum logic [2:0] {
        ERR_OK   = 3'd0,
        ERR_VER  = 3'd1,
        ERR_CHKS = 3'd2,
        ERR_DST  = 3'd3,
        ERR_FRAG = 3'd4,
        ERR_LEN  = 3'd5
    } err_t;

    // A sum of two 16-bit words never overflows again after one fold.
    function automatic logic [15:0] ones_fold17(input logic [16:0] raw);
        return raw[15:0] + {15'd0, raw[16]};
    endfunction

endpackage

// File: rtl/ones_add16.sv
// Combinational 16-bit ones-complement adder with end-around carry.
module ones_add16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum
);
    import ip_pkg::*;

    logic [16:0] raw;

    assign raw = {1'b0, a} + {1'b0, b};
    assign sum = ones_fold17(raw);

endmodule

// File: rtl/ip_rx_check.sv
// Receive-side IPv4 header checker: verifies a 20-byte header and forwards the payload.
// Build option IP_RX_BROADCAST_EN: also accept destination 255.255.255.255.
module ip_rx_check (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    input  logic        i_sof,
    output logic        o_ready,
    input  logic        i_set_local,
    input  logic [7:0]  i_ip0,
    input  logic [7:0]  i_ip1,
    input  logic [7:0]  i_ip2,
    input  logic [7:0]  i_ip3,
    output logic        o_hdr_done,
    output logic        o_hdr_ok,
    output logic [2:0]  o_err,
    output logic [15:0] o_pl_len,
    output logic [7:0]  o_protocol,
    output logic [31:0] o_src_ip,
    output logic        o_pl_valid,
    output logic [7:0]  o_pl_byte,
    output logic        o_pl_last
);
    import ip_pkg::*;

    state_t      state;
    logic [4:0]  idx;
    logic [15:0] csum;
    logic [7:0]  hi_byte;
    logic [7:0]  ver_ihl;
    logic [15:0] total_len;
    logic [13:0] frag;
    logic [7:0]  protocol;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [31:0] local_ip;
    logic        set_local_q;
    logic [15:0] remaining;

    logic [15:0] word_sum;
    logic        start_hdr;
    logic        hdr_take;
    logic        pl_take;
    logic [4:0]  byte_idx;
    logic        dst_ok;
    logic        len_bad;
    logic [15:0] pl_len_calc;
    err_t        err;

    ones_add16 u_add (
        .a   (csum),
        .b   ({hi_byte, i_byte}),
        .sum (word_sum)
    );

    // A start-of-frame byte always restarts the header, except in the one-cycle CHECK gap.
    always_comb begin
        start_hdr   = i_valid & i_sof & (state != S_CHECK);
        hdr_take    = i_valid & (start_hdr | (state == S_HEADER));
        pl_take     = i_valid & ~i_sof & (state == S_PAYLOAD);
        byte_idx    = start_hdr ? 5'd0 : idx;
        len_bad     = total_len < HDR_LEN;
        pl_len_calc = total_len - HDR_LEN;
`ifdef IP_RX_BROADCAST_EN
        dst_ok      = (dst_ip == local_ip) | (dst_ip == BROADCAST_IP);
`else
        dst_ok      = (dst_ip == local_ip);
`endif
        if (ver_ihl != VER_IHL)              err = ERR_VER;
        else if (csum != 16'hFFFF)           err = ERR_CHKS;
        else if (len_bad)                    err = ERR_LEN;
        else if (frag[13] || frag[12:0] != 13'd0) err = ERR_FRAG;
        else if (!dst_ok)                    err = ERR_DST;
        else                                 err = ERR_OK;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            set_local_q <= 1'b0;
            local_ip    <= DEFAULT_LOCAL_IP;
        end else begin
            set_local_q <= i_set_local;
            if (i_set_local && !set_local_q)
                local_ip <= {i_ip0, i_ip1, i_ip2, i_ip3};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_IDLE;
            idx        <= 5'd0;
            csum       <= 16'd0;
            hi_byte    <= 8'd0;
            ver_ihl    <= 8'd0;
            total_len  <= 16'd0;
            frag       <= 14'd0;
            protocol   <= 8'd0;
            src_ip     <= 32'd0;
            dst_ip     <= 32'd0;
            remaining  <= 16'd0;
            o_ready    <= 1'b1;
            o_hdr_done <= 1'b0;
            o_hdr_ok   <= 1'b0;
            o_err      <= 3'd0;
            o_pl_len   <= 16'd0;
            o_protocol <= 8'd0;
            o_src_ip   <= 32'd0;
            o_pl_valid <= 1'b0;
            o_pl_byte  <= 8'd0;
            o_pl_last  <= 1'b0;
        end else begin
            o_hdr_done <= 1'b0;
            o_pl_valid <= 1'b0;
            o_pl_last  <= 1'b0;
            o_ready    <= 1'b1;

            if (hdr_take) begin
                idx <= byte_idx + 5'd1;
                if (start_hdr)
                    csum <= 16'd0;
                else if (byte_idx[0])
                    csum <= word_sum;
                if (!byte_idx[0])
                    hi_byte <= i_byte;
                if (byte_idx == 5'd0)
                    ver_ihl <= i_byte;
                if (byte_idx == OFF_LEN)
                    total_len[15:8] <= i_byte;
                if (byte_idx == OFF_LEN + 5'd1)
                    total_len[7:0] <= i_byte;
                if (byte_idx == OFF_FLAGS)
                    frag[13:8] <= i_byte[5:0];
                if (byte_idx == OFF_FLAGS + 5'd1)
                    frag[7:0] <= i_byte;
                if (byte_idx == OFF_PROTO)
                    protocol <= i_byte;
                if (byte_idx >= OFF_SRC && byte_idx < OFF_DST)
                    src_ip <= {src_ip[23:0], i_byte};
                if (byte_idx >= OFF_DST)
                    dst_ip <= {dst_ip[23:0], i_byte};
            end

            // A restart inside an unfinished header reports that header as truncated.
            if (start_hdr) begin
                state <= S_HEADER;
                if (state == S_HEADER) begin
                    o_hdr_done <= 1'b1;
                    o_hdr_ok   <= 1'b0;
                    o_err      <= ERR_LEN;
                end
            end else begin
                case (state)
                    S_HEADER: begin
                        if (i_valid && idx == HDR_LAST) begin
                            state   <= S_CHECK;
                            o_ready <= 1'b0;
                        end
                    end
                    S_CHECK: begin
                        o_hdr_done <= 1'b1;
                        o_hdr_ok   <= (err == ERR_OK);
                        o_err      <= err;
                        o_protocol <= protocol;
                        o_src_ip   <= src_ip;
                        o_pl_len   <= len_bad ? 16'd0 : pl_len_calc;
                        remaining  <= len_bad ? 16'd0 : pl_len_calc;
                        if (err != ERR_OK)
                            state <= S_DROP;
                        else if (pl_len_calc != 16'd0)
                            state <= S_PAYLOAD;
                        else
                            state <= S_IDLE;
                    end
                    S_PAYLOAD: begin
                        if (pl_take) begin
                            o_pl_valid <= 1'b1;
                            o_pl_byte  <= i_byte;
                            remaining  <= remaining - 16'd1;
                            if (remaining == 16'd1) begin
                                o_pl_last <= 1'b1;
                                state     <= S_IDLE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
